spi_command_frontend: RTL
=========================

// Module: spi_command_frontend
// PURPOSE
//   SPI mode-0 slave front end for the register file. Deserialises 8-bit MOSI
//   frames into load strobes and data for the A/B/O registers, and shifts the
//   current O register value back out on MISO during the same frame.
//   Sits between the chip pins and the register file/ALU.
// PARAMETERS
//   SYNC_STAGES  2  flops per pin synchroniser (sclk, cs_n, mosi); >=2
//   DATA_WIDTH   4  A/B operand width (frame bits [3:0])
//   OUT_WIDTH    8  O register width; also MISO frame length (fixed at 8)
// PORTS
//   clk        in   1  system clock; must be >= 4x spi_sclk frequency
//   reset      in   1  synchronous, active-high reset
//   spi_sclk   in   1  SPI clock (async to clk)
//   spi_cs_n   in   1  SPI chip select, active low (async)
//   spi_mosi   in   1  SPI data in, MSB first (async)
//   spi_miso   out  1  SPI data out, MSB first; 0 when not in a frame
//   o_data     in   8  O register contents (Oout of register file)
//   a_data     out  4  value for A register (AIn)
//   b_data     out  4  value for B register (BIn)
//   alu_op     out  3  ALU operation select
//   lda/ldb/ldo out 1  one-cycle load strobes for A/B/O
//   frame_err  out  1  one-cycle pulse: cs_n rose before 8 bits received
//   cmd_err    out  1  one-cycle pulse: reserved opcode received
// BEHAVIOUR
//   Reset: all outputs 0; state WAIT_CS; bit_cnt, rx/tx shifters 0; sclk/mosi
//     sync chains reset 0; cs_n sync chain reset 0 (so mid-frame reset never
//     yields a false cs_n fall). All signals below use synchronised versions.
//   Edges: sclk_rise = sync 0->1, sclk_fall = 1->0, cs_fall/cs_rise likewise.
//   FSM:
//     WAIT_CS: ignore sclk; -> IDLE when cs_n==1.
//     IDLE:    spi_miso=0; on cs_fall -> SHIFT, bit_cnt=0, tx_shift<=o_data,
//              spi_miso<=o_data[7].
//     SHIFT:   sclk_rise: rx_shift<={rx_shift[6:0],mosi}, bit_cnt++;
//              after 8th rise -> EXEC. sclk_fall: tx_shift<<=1,
//              spi_miso<=tx_shift[6]. cs_rise before 8 rises -> frame_err
//              pulse, -> IDLE, no strobes, a/b/alu_op unchanged.
//     EXEC:    one cycle; registered decode of rx_shift; -> WAIT_CS.
//   Decode (op=rx[7:4], arg=rx[3:0]), outputs registered, strobes 1 cycle:
//     0x0 NOP; 0x1 a_data<=arg, lda=1; 0x2 b_data<=arg, ldb=1;
//     0x3-0x7 reserved: cmd_err=1, no other change;
//     0x8-0xF alu_op<=op[2:0], ldo=1 (arg ignored).
//   Strobes asserted the cycle after EXEC entry; data/alu_op valid in the same
//     cycle and held until next write, so register file captures next edge.
//   Pin-to-strobe latency: SYNC_STAGES+2 clk after 8th sclk rise at the pin.
//   Extra sclk edges after bit 8 (same frame) ignored; MISO holds 0 after bit 8.
//   o_data sampled only at cs_fall; later O updates appear in the next frame.
//   cs_fall and sclk_rise in same cycle: cs_fall wins, that sclk edge dropped.
//   Simultaneous reset and any event: reset wins.
// TESTING
//   1. Frame 0x1A -> lda=1 one cycle, a_data=4'hA; ldb/ldo/errs stay 0.
//   2. Frames 0x13, 0x25, 0x9F -> a=3, b=5, alu_op=3'b001, ldo pulse once.
//   3. o_data=8'hC5 before cs_n fall, send any frame -> MISO bits 1,1,0,0,0,1,0,1.
//   4. cs_n high after 5 sclk rises -> frame_err pulse, no strobes; next full
//      frame 0x27 decodes correctly (ldb, b_data=7).
//   5. Frame 0x5x -> cmd_err pulse, a/b/alu_op and strobes unchanged.
//   6. reset asserted mid-frame with cs_n held low -> outputs 0, remaining bits
//      ignored; after cs_n high then new frame 0x1F -> lda, a_data=F.

Source files
------------

// File: rtl/spi_command_frontend.sv
// SPI mode-0 slave front end: synchronises the SPI pins, deserialises one
// 8-bit command frame per chip-select window, decodes it into register-file
// load strobes / ALU op select, and shifts the O register out on MISO.
module spi_command_frontend #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_WIDTH  = 4,
    parameter int OUT_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    input  logic [OUT_WIDTH-1:0]  o_data,
    output logic [DATA_WIDTH-1:0] a_data,
    output logic [DATA_WIDTH-1:0] b_data,
    output logic [2:0]            alu_op,
    output logic                  lda,
    output logic                  ldb,
    output logic                  ldo,
    output logic                  frame_err,
    output logic                  cmd_err
);

    // Command frames are as long as the MISO frame (one O register).
    localparam int FRAME_BITS = OUT_WIDTH;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        WAIT_CS,
        IDLE,
        SHIFT,
        EXEC
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronisers: {sclk, cs_n, mosi} travel together through the
    // chain so their relative timing is preserved. All stages reset to 0,
    // which keeps a reset taken with cs_n held low from looking like a
    // fresh cs_n fall afterwards.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES:0][2:0] sync_chain;

    assign sync_chain[0] = {spi_sclk, spi_cs_n, spi_mosi};

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic [2:0] stage_reg;

            // One synchroniser flop stage for all three pins
            always_ff @(posedge clk) begin
                if (reset) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= sync_chain[gi];
                end
            end

            assign sync_chain[gi+1] = stage_reg;
        end
    endgenerate

    logic sclk_s;
    logic cs_s;
    logic mosi_s;

    assign sclk_s = sync_chain[SYNC_STAGES][2];
    assign cs_s   = sync_chain[SYNC_STAGES][1];
    assign mosi_s = sync_chain[SYNC_STAGES][0];

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                state_reg,     state_next;
    logic [CNT_W-1:0]      bit_cnt_reg,   bit_cnt_next;
    logic [FRAME_BITS-1:0] rx_shift_reg,  rx_shift_next;
    logic [OUT_WIDTH-1:0]  tx_shift_reg,  tx_shift_next;
    logic                  miso_reg,      miso_next;
    logic [DATA_WIDTH-1:0] a_reg,         a_next;
    logic [DATA_WIDTH-1:0] b_reg,         b_next;
    logic [2:0]            alu_op_reg,    alu_op_next;
    logic                  lda_reg,       lda_next;
    logic                  ldb_reg,       ldb_next;
    logic                  ldo_reg,       ldo_next;
    logic                  frame_err_reg, frame_err_next;
    logic                  cmd_err_reg,   cmd_err_next;
    logic                  sclk_prev_reg;
    logic                  cs_prev_reg;

    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;

    assign sclk_rise = sclk_s & ~sclk_prev_reg;
    assign sclk_fall = ~sclk_s & sclk_prev_reg;
    assign cs_rise   = cs_s & ~cs_prev_reg;
    assign cs_fall   = ~cs_s & cs_prev_reg;

    logic [3:0]            dec_op;
    logic [DATA_WIDTH-1:0] dec_arg;

    assign dec_op  = rx_shift_reg[FRAME_BITS-1 -: 4];
    assign dec_arg = rx_shift_reg[DATA_WIDTH-1:0];

    // Register update: state, shifters, decoded outputs and edge history
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= WAIT_CS;
            bit_cnt_reg   <= '0;
            rx_shift_reg  <= '0;
            tx_shift_reg  <= '0;
            miso_reg      <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            alu_op_reg    <= '0;
            lda_reg       <= 1'b0;
            ldb_reg       <= 1'b0;
            ldo_reg       <= 1'b0;
            frame_err_reg <= 1'b0;
            cmd_err_reg   <= 1'b0;
            sclk_prev_reg <= 1'b0;
            cs_prev_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            rx_shift_reg  <= rx_shift_next;
            tx_shift_reg  <= tx_shift_next;
            miso_reg      <= miso_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            alu_op_reg    <= alu_op_next;
            lda_reg       <= lda_next;
            ldb_reg       <= ldb_next;
            ldo_reg       <= ldo_next;
            frame_err_reg <= frame_err_next;
            cmd_err_reg   <= cmd_err_next;
            sclk_prev_reg <= sclk_s;
            cs_prev_reg   <= cs_s;
        end
    end

    // Next-state, shifting and command decode
    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        rx_shift_next  = rx_shift_reg;
        tx_shift_next  = tx_shift_reg;
        miso_next      = miso_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        alu_op_next    = alu_op_reg;
        lda_next       = 1'b0;
        ldb_next       = 1'b0;
        ldo_next       = 1'b0;
        frame_err_next = 1'b0;
        cmd_err_next   = 1'b0;

        case (state_reg)
            WAIT_CS: begin
                // Finish the current chip-select window before arming again
                miso_next = 1'b0;
                if (cs_s) begin
                    state_next = IDLE;
                end
            end

            IDLE: begin
                miso_next = 1'b0;
                // cs_fall takes priority; a coincident sclk edge is dropped
                if (cs_fall) begin
                    state_next    = SHIFT;
                    bit_cnt_next  = '0;
                    tx_shift_next = o_data;
                    miso_next     = o_data[OUT_WIDTH-1];
                end
            end

            SHIFT: begin
                if (cs_rise) begin
                    // Frame cut short: discard it, leave outputs untouched
                    frame_err_next = 1'b1;
                    miso_next      = 1'b0;
                    state_next     = IDLE;
                end else if (sclk_rise) begin
                    rx_shift_next = {rx_shift_reg[FRAME_BITS-2:0], mosi_s};
                    bit_cnt_next  = bit_cnt_reg + CNT_W'(1);
                    if (bit_cnt_reg == CNT_W'(FRAME_BITS - 1)) begin
                        state_next = EXEC;
                        miso_next  = 1'b0;
                    end
                end else if (sclk_fall) begin
                    tx_shift_next = tx_shift_reg << 1;
                    miso_next     = tx_shift_reg[OUT_WIDTH-2];
                end
            end

            EXEC: begin
                miso_next  = 1'b0;
                state_next = WAIT_CS;
                case (dec_op)
                    4'h0: ;
                    4'h1: begin
                        a_next   = dec_arg;
                        lda_next = 1'b1;
                    end
                    4'h2: begin
                        b_next   = dec_arg;
                        ldb_next = 1'b1;
                    end
                    4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                        cmd_err_next = 1'b1;
                    end
                    default: begin
                        alu_op_next = dec_op[2:0];
                        ldo_next    = 1'b1;
                    end
                endcase
            end

            default: begin
                state_next = WAIT_CS;
            end
        endcase
    end

    assign spi_miso  = miso_reg;
    assign a_data    = a_reg;
    assign b_data    = b_reg;
    assign alu_op    = alu_op_reg;
    assign lda       = lda_reg;
    assign ldb       = ldb_reg;
    assign ldo       = ldo_reg;
    assign frame_err = frame_err_reg;
    assign cmd_err   = cmd_err_reg;

endmodule
